seg7_scanner: RTL and testbench
===============================

Name: seg7_scanner

Overview:
- Multiplexed 8-digit seven-segment display driver; the output-side counterpart of the keypad matrix scanner.
- Strobes one active-low digit-select line at a time and drives active-low segment patterns decoded from a 32-bit hex word.
- Inserts a blanking gap between digits to prevent ghosting.
- Latches display data only at frame boundaries, so a frame never shows a mix of old and new values.
- Sits between game/control logic and the board's common-anode display pins.

Parameters:
- DIGITS, 8, number of digits scanned (1..8).
- DWELL_CYCLES, 100000, clock cycles each digit is lit (>=1).
- BLANK_CYCLES, 1000, clock cycles all digits are dark before each digit (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- data  input  32  hex nibbles; digit i shows data[4i+3:4i].
- dp  input  8  decimal point per digit, 1 = lit.
- digit_en  input  8  per-digit enable, 0 = digit stays dark in its slot.
- seg_en  output  8  digit select, active-low, one-hot-low when lit.
- seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse in the last SHOW cycle of the last digit.

Behaviour:
- Reset: state=LOAD, idx=0, cnt=0, shadow registers=0, seg_en=8'hFF, seg_out=8'hFF, frame_done=0. All outputs are registered.
- State LOAD (1 cycle):
  - shadow_data/shadow_dp/shadow_en <= data/dp/digit_en.
  - idx <= 0, cnt <= 0, outputs dark, next state BLANK.
- State BLANK:
  - seg_en=FF, seg_out=FF.
  - cnt counts 0..BLANK_CYCLES-1; at the final count, cnt <= 0 and next state SHOW.
- State SHOW:
  - If shadow_en[idx]: seg_en has bit idx low and all others high; seg_out = decode(shadow nibble idx) with dp bit = ~shadow_dp[idx].
  - If not shadow_en[idx]: seg_en=FF and seg_out=FF. The slot time is still consumed, so brightness stays constant.
  - cnt counts 0..DWELL_CYCLES-1. At the final count: if idx==DIGITS-1, assert frame_done and go to LOAD; otherwise idx <= idx+1, cnt <= 0, go to BLANK.
- Output timing: registered outputs reflect the state entered, i.e. they are valid on the first cycle of that state.
- Frame length: exactly 1 + DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Input sampling: inputs are sampled only in LOAD; changes at any other time are ignored until the next frame.
- Hex decode: 0-F to standard patterns, active-low, e.g. 0 -> 7'b1000000 (gfedcba), 8 -> 7'b0000000, F -> 7'b0001110.
- Counter width: $clog2 of max(DWELL_CYCLES, BLANK_CYCLES)+1. No wrap occurs beyond the terminal count.
- Digits idx >= DIGITS are never visited.
- Reset mid-frame: outputs go dark immediately (async); scanning restarts with LOAD on the first clock after release.
- Invariant: at most one seg_en bit is low in any cycle.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- When defined:
  - Adds input blink[7:0] (latched in LOAD like the other inputs).
  - Adds parameter BLINK_FRAMES, default 250.
  - A frame counter toggles a blink phase every BLINK_FRAMES frames.
  - While the phase is 1, digits with shadow_blink set are forced dark in SHOW.
  - Phase and frame counter reset to 0.
- When undefined: no blink port, counter or logic; behaviour is exactly as above.

Decomposition:
- Package seg7_pkg: state encoding (LOAD, BLANK, SHOW), SEG_OFF=8'hFF, the 16-entry active-low hex segment constant table.
- Sub-module seg7_hex_decode: combinational 4-bit nibble to 7-bit active-low pattern. It is instantiated once on the muxed shadow nibble.

Test Plan (DIGITS=8, DWELL_CYCLES=8, BLANK_CYCLES=2):
- Frame timing: release reset with data=32'h76543210, dp=0, digit_en=FF.
  - frame_done pulses every 81 cycles.
  - Each digit is lit 8 cycles, preceded by 2 dark cycles.
  - seg_en sequence FE,FD,...,7F.
  - Digit 0 shows seg_out=8'hC0 and digit 1 shows 8'hF9.
- Tear-free update: change data to 32'hFFFFFFFF in the middle of digit 3.
  - Digits 3-7 of the current frame still show 3..7.
  - The next frame shows F (seg_out=8'h8E) on all digits.
- Enable and decimal point: digit_en=8'b10101010, dp=8'h01.
  - Even slots keep seg_en=FF for their full 8 cycles.
  - Digit 0 never lights, so its dp is not visible.
  - Frame length stays 81 cycles.
- Async reset: assert rst mid-SHOW between clock edges.
  - seg_en=FF, seg_out=FF and frame_done=0 immediately.
  - After release, LOAD occurs, then digit 0 lights on cycle 4 after the first edge.
- One-hot assertion: over 10 random-data frames, popcount(~seg_en) <= 1 in every cycle, and it is 0 in all LOAD and BLANK cycles.
- SEG7_BLINK_EN with BLINK_FRAMES=2, blink=8'h01: digit 0 is lit in frames 0-1, dark in frames 2-3, and lit again in frames 4-5; other digits are unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: scan states,
// the dark output code and the active-low hex glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Glyphs in {g,f,e,d,c,b,a} order, active-low; leftmost entry is nibble F.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [7:0] digit_select(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed 8-digit common-anode display driver with inter-digit blanking and
// frame-boundary data latching. Optional blink support under `SEG7_BLINK_EN.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
`ifdef SEG7_BLINK_EN
  input  logic [7:0]  blink,
`endif
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic        frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = 3;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;

  logic [31:0]     r_sh_data;
  logic [7:0]      r_sh_dp;
  logic [7:0]      r_sh_en;

  logic [7:0]      r_seg_en;
  logic [7:0]      r_seg_out;
  logic            r_frame_done;

  logic            w_load;
  logic            w_frame_end;
  logic            w_lit;
  logic            w_blanked;
  logic            w_fd_nx;
  logic [3:0]      w_nibble;
  logic [6:0]      w_glyph;
  logic [7:0]      w_seg_en_nx;
  logic [7:0]      w_seg_out_nx;

  assign w_nibble = r_sh_data[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [7:0]    r_sh_blink;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;

  // Phase flips once every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_blink <= 8'h00;
      r_fcnt     <= '0;
      r_phase    <= 1'b0;
    end else begin
      if (w_load)
        r_sh_blink <= blink;
      if (w_frame_end) begin
        if (r_fcnt == FRAME_LAST) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
    end
  end

  assign w_blanked = r_phase & r_sh_blink[r_idx];
`else
  assign w_blanked = 1'b0;
`endif

  // Next-state, and the outputs that belong to the state being entered.
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_cnt_nx     = r_cnt;
    w_load       = 1'b0;
    w_frame_end  = 1'b0;
    w_lit        = 1'b0;
    w_seg_en_nx  = SEG_OFF;
    w_seg_out_nx = SEG_OFF;
    w_fd_nx      = 1'b0;

    case (r_state)
      ST_LOAD: begin
        w_load     = 1'b1;
        w_idx_nx   = '0;
        w_cnt_nx   = '0;
        w_state_nx = ST_BLANK;
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_SHOW;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_nx = '0;
          if (r_idx == LAST_IDX) begin
            w_frame_end = 1'b1;
            w_idx_nx    = '0;
            w_state_nx  = ST_LOAD;
          end else begin
            w_idx_nx   = r_idx + IW'(1);
            w_state_nx = ST_BLANK;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_idx_nx   = '0;
        w_cnt_nx   = '0;
        w_state_nx = ST_LOAD;
      end
    endcase

    // Entering or staying in SHOW never changes idx, so r_idx selects the digit.
    w_lit = (w_state_nx == ST_SHOW) && r_sh_en[r_idx] && !w_blanked;
    if (w_lit) begin
      w_seg_en_nx  = digit_select(r_idx);
      w_seg_out_nx = {~r_sh_dp[r_idx], w_glyph};
    end

    w_fd_nx = (w_state_nx == ST_SHOW) && (w_idx_nx == LAST_IDX) && (w_cnt_nx == DWELL_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Shadow copies are only refreshed at the frame boundary to keep frames tear-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_data <= 32'h0;
      r_sh_dp   <= 8'h00;
      r_sh_en   <= 8'h00;
    end else if (w_load) begin
      r_sh_data <= data;
      r_sh_dp   <= dp;
      r_sh_en   <= digit_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_en     <= SEG_OFF;
      r_seg_out    <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_en     <= w_seg_en_nx;
      r_seg_out    <= w_seg_out_nx;
      r_frame_done <= w_fd_nx;
    end
  end

  assign seg_en     = r_seg_en;
  assign seg_out    = r_seg_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed + randomized bench for seg7_scanner; the reference model derives the
// expected outputs from each cycle's position inside the frame.
module tb_seg7_scanner;

  localparam int DIG  = 8;
  localparam int DW   = 8;
  localparam int BL   = 2;
  localparam int SLOT = BL + DW;
  localparam int FLEN = 1 + DIG * SLOT;
  localparam int BF   = 2;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  digit_en = 8'h00;
  logic [7:0]  blink = 8'h00;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scanner #(
    .DIGITS       (DIG),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .digit_en   (digit_en),
`ifdef SEG7_BLINK_EN
    .blink      (blink),
`endif
    .seg_en     (seg_en),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int p       = 0;   // position in frame: 0 = LOAD cycle
  int frame   = 0;   // completed frames since reset
  int cyc     = 0;
  int last_fd = -1;

  logic [31:0] m_data  = 32'h0;
  logic [7:0]  m_dp    = 8'h00;
  logic [7:0]  m_en    = 8'h00;
  logic [7:0]  m_blink = 8'h00;

  // Standard active-low glyphs {dp,g..a} with the decimal point off.
  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h (frame pos %0d)", tag, obs, exp, p);
    end
  endtask

  task automatic model(output logic [7:0] e_en, output logic [7:0] e_seg, output logic e_fd);
    int k, slot, off;
    logic [3:0] nib;
    bit dark_blink;
    e_en  = 8'hFF;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
    if (p != 0) begin
      k    = p - 1;
      slot = k / SLOT;
      off  = k % SLOT;
      dark_blink = BLINK_ON && (((frame / BF) % 2) == 1) && m_blink[slot];
      if (off >= BL && m_en[slot] && !dark_blink) begin
        nib   = m_data[slot*4 +: 4];
        e_en  = 8'hFF;
        e_en[slot] = 1'b0;
        e_seg = GLYPH[nib];
        if (m_dp[slot]) e_seg[7] = 1'b0;
      end
      e_fd = (slot == DIG - 1) && (off == SLOT - 1);
    end
  endtask

  // Check the current cycle, then advance one clock; entered and left at negedge.
  task automatic cycle();
    logic [7:0] e_en, e_seg;
    logic e_fd;
    model(e_en, e_seg, e_fd);
    chk("seg_en", {24'h0, seg_en}, {24'h0, e_en});
    chk("seg_out", {24'h0, seg_out}, {24'h0, e_seg});
    chk("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
    n_tests++;
    assert ($countones(~seg_en) <= 1) else begin
      n_fail++;
      $error("FAIL onehot: got seg_en %h, expected at most one low bit", seg_en);
    end
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("fd_period", cyc - last_fd, FLEN);
      last_fd = cyc;
    end
    if (p == 0) begin
      m_data  = data;
      m_dp    = dp;
      m_en    = digit_en;
      m_blink = blink;
    end
    @(posedge clk);
    cyc++;
    if (p == FLEN - 1) begin
      p = 0;
      frame++;
    end else begin
      p++;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FLEN + 1 && p != target; i++) cycle();
    chk("run_to", p, target);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst     = 1'b0;
    p       = 0;
    frame   = 0;
    last_fd = -1;
  endtask

  initial begin
    // Reset state while rst is held from time 0.
    @(negedge clk);
    chk("rst_seg_en", {24'h0, seg_en}, 32'hFF);
    chk("rst_seg_out", {24'h0, seg_out}, 32'hFF);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);

    // Frame timing with digits 0..7.
    data     = 32'h76543210;
    dp       = 8'h00;
    digit_en = 8'hFF;
    release_reset();
    run_to(3);
    chk("digit0_glyph", {24'h0, seg_out}, 32'hC0);
    chk("digit0_sel", {24'h0, seg_en}, 32'hFE);
    run_to(13);
    chk("digit1_glyph", {24'h0, seg_out}, 32'hF9);
    for (int i = 0; i < 2 * FLEN; i++) cycle();

    // Tear-free update: new data arrives while digit 3 is lit.
    run_to(36);
    data = 32'hFFFFFFFF;
    run_to(73);
    chk("torn_digit7", {24'h0, seg_out}, 32'hF8);
    run_to(3);
    chk("new_frame_F", {24'h0, seg_out}, 32'h8E);
    for (int i = 0; i < FLEN; i++) cycle();

    // Odd digits only, dp requested on hidden digit 0.
    data     = 32'h76543210;
    digit_en = 8'b1010_1010;
    dp       = 8'h01;
    run_to(0);
    for (int i = 0; i < 2 * FLEN; i++) cycle();

    // Asynchronous reset between edges on the frame_done cycle.
    digit_en = 8'hFF;
    dp       = 8'h00;
    run_to(0);
    run_to(FLEN - 1);
    chk("pre_rst_fd", {31'h0, frame_done}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_seg_en", {24'h0, seg_en}, 32'hFF);
    chk("async_seg_out", {24'h0, seg_out}, 32'hFF);
    chk("async_fd", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    release_reset();
    for (int i = 0; i < FLEN + 5; i++) cycle();

    // Random inputs changing every cycle over ten frames.
    for (int i = 0; i < 10 * FLEN; i++) begin
      data     = $urandom;
      dp       = 8'($urandom);
      digit_en = 8'($urandom);
      cycle();
    end

`ifdef SEG7_BLINK_EN
    // Blink digit 0 every two frames.
    @(negedge clk);
    rst      = 1'b1;
    digit_en = 8'hFF;
    dp       = 8'h00;
    data     = $urandom;
    blink    = 8'h01;
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 6 * FLEN; i++) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
